// File: rtl/iddmm_pkg.sv
// -----------------------------------------------------------------------------
// iddmm_pkg
// Shared definitions for the IDDMM output-side blocks.
//   K_DEF      : default bits per word
//   N_DEF      : default words per operand
//   ADDR_W_DEF : default word index width
//   sel_state_t: result selector FSM states (COLLECT, DRAIN)
// -----------------------------------------------------------------------------
package iddmm_pkg;

    localparam int unsigned K_DEF      = 128;
    localparam int unsigned N_DEF      = 32;
    localparam int unsigned ADDR_W_DEF = $clog2(N_DEF);

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } sel_state_t;

endpackage : iddmm_pkg

// File: rtl/iddmm_word_fifo.sv
// -----------------------------------------------------------------------------
// iddmm_word_fifo
// First-word-fall-through word buffer, W bits wide and DEPTH words deep.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : write strobe; accepted when not full, or when popping
//   pop_i      : remove head word (ignored when empty)
//   din_i      : write data
//   dout_o     : head word (valid whenever count_o != 0)
//   count_o    : occupancy, 0..DEPTH
//   full_o     : count_o == DEPTH
// -----------------------------------------------------------------------------
module iddmm_word_fifo #(
    parameter int unsigned W     = 128,
    parameter int unsigned DEPTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [W-1:0]                 din_i,
    output logic [W-1:0]                 dout_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop_i && (cnt_q != '0);
    // A push to a full buffer is still accepted when a pop frees a slot.
    assign do_push = push_i && (!full_o || do_pop);

    assign dout_o  = mem_q[rptr_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= ptr_inc(wptr_q);
            end
            if (do_pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule : iddmm_word_fifo

// File: rtl/iddmm_result_sel.sv
// -----------------------------------------------------------------------------
// iddmm_result_sel
// Captures the raw (A) and reduced (A-P) final-row word streams, latches the
// end-of-calculation sign and replays the selected N words, LSW first, over a
// valid/ready interface. The unselected stream is popped in lockstep.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   fifo_wr_en_a      : raw-result word strobe
//   fifo_wr_data_a    : raw-result word (index 0 first)
//   fifo_wr_en_sub    : reduced-result word strobe
//   fifo_wr_data_sub  : reduced-result word (index 0 first)
//   cal_done          : one-cycle end-of-calculation pulse
//   cal_sign          : with cal_done; 1 selects sub stream, 0 selects a stream
//   o_valid, o_data   : output word and its valid
//   o_idx, o_last     : output word index (0..N-1), high on index N-1
//   i_ready           : downstream accept
//   busy              : high while draining
//   overflow          : sticky error (dropped word or third cal_done)
// -----------------------------------------------------------------------------
module iddmm_result_sel
    import iddmm_pkg::*;
#(
    parameter int unsigned K      = K_DEF,
    parameter int unsigned N      = N_DEF,
    parameter int unsigned ADDR_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_wr_en_a,
    input  logic [K-1:0]      fifo_wr_data_a,
    input  logic              fifo_wr_en_sub,
    input  logic [K-1:0]      fifo_wr_data_sub,
    input  logic              cal_done,
    input  logic              cal_sign,
    output logic              o_valid,
    output logic [K-1:0]      o_data,
    output logic [ADDR_W-1:0] o_idx,
    output logic              o_last,
    input  logic              i_ready,
    output logic              busy,
    output logic              overflow
);

    localparam int unsigned CW = $clog2(N + 1);

    logic [K-1:0]      head_a;
    logic [K-1:0]      head_sub;
    logic [CW-1:0]     cnt_a;
    logic [CW-1:0]     cnt_sub;
    logic              full_a;
    logic              full_sub;

    sel_state_t        state_q;
    logic [ADDR_W-1:0] idx_q;
    logic              sel_q,      sel_d;
    logic              sel_vld_q,  sel_vld_d;
    logic              sel_pend_q, sel_pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic              overflow_q;

    logic              in_drain;
    logic              hs;
    logic              last_hs;
    logic              drain_go;
    logic              drop_a;
    logic              drop_sub;
    logic              sign_ovf;

    assign in_drain = (state_q == DRAIN);
    assign hs       = in_drain && i_ready;
    assign last_hs  = hs && (idx_q == ADDR_W'(N - 1));
    assign drain_go = (state_q == COLLECT) && (cnt_a == CW'(N)) &&
                      (cnt_sub == CW'(N)) && sel_vld_q;

    // A write to a full buffer is only lost when no pop happens that cycle.
    assign drop_a   = fifo_wr_en_a   && full_a   && !hs;
    assign drop_sub = fifo_wr_en_sub && full_sub && !hs;

    iddmm_word_fifo #(
        .W     (K),
        .DEPTH (N)
    ) buf_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_wr_en_a),
        .pop_i   (hs),
        .din_i   (fifo_wr_data_a),
        .dout_o  (head_a),
        .count_o (cnt_a),
        .full_o  (full_a)
    );

    iddmm_word_fifo #(
        .W     (K),
        .DEPTH (N)
    ) buf_sub (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_wr_en_sub),
        .pop_i   (hs),
        .din_i   (fifo_wr_data_sub),
        .dout_o  (head_sub),
        .count_o (cnt_sub),
        .full_o  (full_sub)
    );

    // Sign latch: the final handshake releases the current sign first, so a
    // cal_done in that same cycle sees the freed slot (direct load, or the
    // pending slot if the pending sign was just promoted).
    always_comb begin
        sel_d      = sel_q;
        sel_vld_d  = sel_vld_q;
        sel_pend_d = sel_pend_q;
        pend_vld_d = pend_vld_q;
        sign_ovf   = 1'b0;
        if (last_hs) begin
            if (pend_vld_q) begin
                sel_d      = sel_pend_q;
                pend_vld_d = 1'b0;
            end else begin
                sel_vld_d  = 1'b0;
            end
        end
        if (cal_done) begin
            if (!sel_vld_d) begin
                sel_d      = cal_sign;
                sel_vld_d  = 1'b1;
            end else if (!pend_vld_d && in_drain) begin
                sel_pend_d = cal_sign;
                pend_vld_d = 1'b1;
            end else begin
                sign_ovf   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q      <= 1'b0;
            sel_vld_q  <= 1'b0;
            sel_pend_q <= 1'b0;
            pend_vld_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            sel_q      <= sel_d;
            sel_vld_q  <= sel_vld_d;
            sel_pend_q <= sel_pend_d;
            pend_vld_q <= pend_vld_d;
            overflow_q <= overflow_q | drop_a | drop_sub | sign_ovf;
        end
    end

    // FSM and drain counter. Leaving DRAIN always spends at least one cycle
    // in COLLECT because drain_go is only evaluated from COLLECT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            idx_q   <= '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (drain_go) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_hs) begin
                        state_q <= COLLECT;
                        idx_q   <= '0;
                    end else if (hs) begin
                        idx_q   <= idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= COLLECT;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    // Heads only change on a pop, so outputs hold stable through stalls.
    assign o_valid  = in_drain;
    assign busy     = in_drain;
    assign o_idx    = idx_q;
    assign o_last   = in_drain && (idx_q == ADDR_W'(N - 1));
    assign o_data   = in_drain ? (sel_q ? head_sub : head_a) : '0;
    assign overflow = overflow_q;

endmodule : iddmm_result_sel

// File: tb/tb_iddmm_result_sel.sv
module tb_iddmm_result_sel;
    import iddmm_pkg::*;

    localparam int unsigned K  = 128;
    localparam int unsigned N  = 32;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_wr_en_a = 1'b0;
    logic [K-1:0]  fifo_wr_data_a = '0;
    logic          fifo_wr_en_sub = 1'b0;
    logic [K-1:0]  fifo_wr_data_sub = '0;
    logic          cal_done = 1'b0;
    logic          cal_sign = 1'b0;
    logic          o_valid;
    logic [K-1:0]  o_data;
    logic [AW-1:0] o_idx;
    logic          o_last;
    logic          i_ready = 1'b1;
    logic          busy;
    logic          overflow;

    iddmm_result_sel #(
        .K      (K),
        .N      (N),
        .ADDR_W (AW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fifo_wr_en_a     (fifo_wr_en_a),
        .fifo_wr_data_a   (fifo_wr_data_a),
        .fifo_wr_en_sub   (fifo_wr_en_sub),
        .fifo_wr_data_sub (fifo_wr_data_sub),
        .cal_done         (cal_done),
        .cal_sign         (cal_sign),
        .o_valid          (o_valid),
        .o_data           (o_data),
        .o_idx            (o_idx),
        .o_last           (o_last),
        .i_ready          (i_ready),
        .busy             (busy),
        .overflow         (overflow)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic check(input string name, input logic [K-1:0] act, input logic [K-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Buffers are plain queues; outstanding signs are a queue whose head is
    // the active selection. At most two signs may be outstanding, and the
    // second only while a drain is running.
    logic [K-1:0] qa[$];
    logic [K-1:0] qs[$];
    bit           sq[$];
    bit           m_drain = 1'b0;
    int unsigned  m_idx = 0;
    bit           m_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        bit hs, last, go, was_drain;
        int unsigned s_after;
        if (!rst_n) begin
            qa.delete(); qs.delete(); sq.delete();
            m_drain = 1'b0; m_idx = 0; m_ovf = 1'b0;
        end else begin
            was_drain = m_drain;
            hs   = m_drain && i_ready;
            last = hs && (m_idx == N - 1);
            go   = !m_drain && qa.size() == N && qs.size() == N && sq.size() != 0;
            if (fifo_wr_en_a) begin
                if (qa.size() < N || hs) qa.push_back(fifo_wr_data_a);
                else m_ovf = 1'b1;
            end
            if (fifo_wr_en_sub) begin
                if (qs.size() < N || hs) qs.push_back(fifo_wr_data_sub);
                else m_ovf = 1'b1;
            end
            if (hs) begin
                void'(qa.pop_front());
                void'(qs.pop_front());
                m_idx++;
            end
            if (last) begin
                void'(sq.pop_front());
                m_drain = 1'b0;
                m_idx = 0;
            end
            if (cal_done) begin
                s_after = sq.size();
                if (s_after == 0 || (s_after == 1 && was_drain)) sq.push_back(cal_sign);
                else m_ovf = 1'b1;
            end
            if (go) m_drain = 1'b1;
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        logic [K-1:0] ed;
        if (chk_en) begin
            ed = '0;
            if (m_drain) ed = sq[0] ? qs[0] : qa[0];
            check("m_valid", K'(o_valid), K'(m_drain));
            check("m_busy", K'(busy), K'(m_drain));
            check("m_data", o_data, ed);
            check("m_idx", K'(o_idx), K'(m_drain ? m_idx : 0));
            check("m_last", K'(o_last), K'(m_drain && m_idx == N - 1));
            check("m_ovf", K'(overflow), K'(m_ovf));
        end
    end

    // ---------------- handshake log ----------------
    logic [K-1:0] lg_d[$];
    int unsigned  lg_i[$];
    bit           lg_l[$];
    int unsigned  lg_c[$];
    int unsigned  cyc = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst_n && o_valid && i_ready) begin
            lg_d.push_back(o_data);
            lg_i.push_back(int'(o_idx));
            lg_l.push_back(o_last);
            lg_c.push_back(cyc);
        end
    end

    task automatic clear_log();
        lg_d.delete(); lg_i.delete(); lg_l.delete(); lg_c.delete();
    endtask

    task automatic step(input bit wa, input logic [K-1:0] da, input bit ws,
                        input logic [K-1:0] ds, input bit cd, input bit cs);
        fifo_wr_en_a = wa; fifo_wr_data_a = da;
        fifo_wr_en_sub = ws; fifo_wr_data_sub = ds;
        cal_done = cd; cal_sign = cs;
        @(posedge clk); #1;
        fifo_wr_en_a = 1'b0; fifo_wr_en_sub = 1'b0; cal_done = 1'b0;
    endtask

    task automatic write_both(input int unsigned n, input int unsigned ba, input int unsigned bs);
        for (int unsigned i = 0; i < n; i++) step(1'b1, K'(ba + i), 1'b1, K'(bs + i), 1'b0, 1'b0);
    endtask

    task automatic wait_hs(input int unsigned n, input int unsigned budget, input bit rnd);
        int unsigned b = 0;
        while (lg_d.size() < n && b < budget) begin
            if (rnd) i_ready = ($urandom & 1) != 0;
            @(posedge clk); #1;
            b++;
        end
        i_ready = 1'b1;
        check("hs_count", K'(lg_d.size()), K'(n));
    endtask

    task automatic check_seq(input string name, input int unsigned n, input int unsigned base);
        for (int unsigned i = 0; i < n && i < lg_d.size(); i++) begin
            check({name, "_data"}, lg_d[i], K'(base + i));
            check({name, "_idx"}, K'(lg_i[i]), K'(i % N));
            check({name, "_last"}, K'(lg_l[i]), K'((i % N) == N - 1));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        chk_en = 1'b1;
        // reset state
        check("rst_valid", K'(o_valid), K'(0));
        check("rst_data", o_data, K'(0));
        check("rst_idx", K'(o_idx), K'(0));
        check("rst_ovf", K'(overflow), K'(0));
        do_reset();

        // 1: sel = 0, first word two cycles after cal_done cycle
        clear_log();
        write_both(N, 1, 'h100);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        check("t1_lat0", K'(o_valid), K'(0));
        @(posedge clk); #1;
        check("t1_lat1", K'(o_valid), K'(1));
        wait_hs(N, 100, 1'b0);
        check_seq("t1", N, 1);
        check("t1_contig", K'(lg_c[N-1] - lg_c[0]), K'(N - 1));
        check("t1_busy", K'(busy), K'(0));

        // 2: sel = 1
        clear_log();
        write_both(N, 1, 'h100);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        wait_hs(N, 100, 1'b0);
        check_seq("t2", N, 'h100);
        check("t2_cnt_a", K'(dut.cnt_a), K'(0));
        check("t2_cnt_sub", K'(dut.cnt_sub), K'(0));

        // 3: random backpressure
        clear_log();
        write_both(N, 'h500, 'h600);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        wait_hs(N, 600, 1'b1);
        check_seq("t3", N, 'h600);

        // 4: early cal_done, sub stream finishes last
        clear_log();
        write_both(10, 'h700, 'h800);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        for (int unsigned i = 10; i < N; i++) step(1'b1, K'('h700 + i), 1'b0, '0, 1'b0, 1'b0);
        for (int unsigned i = 10; i < N; i++) step(1'b0, '0, 1'b1, K'('h800 + i), 1'b0, 1'b0);
        check("t4_lat0", K'(o_valid), K'(0));
        @(posedge clk); #1;
        check("t4_lat1", K'(o_valid), K'(1));
        wait_hs(N, 100, 1'b0);
        check_seq("t4", N, 'h700);

        // 5: overlapping calculations with a pending sign
        clear_log();
        write_both(N, 'h900, 'hA00);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        for (int unsigned i = 0; i < N; i++) step(1'b1, K'('hB00 + i), 1'b1, K'('hC00 + i), i == 5, 1'b0);
        wait_hs(2 * N, 200, 1'b0);
        check_seq("t5a", N, 'hA00);
        for (int unsigned i = N; i < 2 * N && i < lg_d.size(); i++)
            check("t5b_data", lg_d[i], K'('hB00 + i - N));
        if (lg_c.size() > N) check("t5_gap", K'(lg_c[N] - lg_c[N-1]), K'(2));
        check("t5_ovf", K'(overflow), K'(0));

        // 6: overflow on the 33rd word, then reset mid-drain
        do_reset();
        clear_log();
        for (int unsigned i = 0; i <= N; i++) step(1'b1, K'('hD00 + i), 1'b0, '0, 1'b0, 1'b0);
        check("t6_ovf", K'(overflow), K'(1));
        check("t6_cnt_a", K'(dut.cnt_a), K'(N));
        for (int unsigned i = 0; i < N; i++) step(1'b0, '0, 1'b1, K'('hE00 + i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        wait_hs(N, 100, 1'b0);
        check_seq("t6", N, 'hD00);
        check("t6_cnt_a_end", K'(dut.cnt_a), K'(0));
        check("t6_ovf_sticky", K'(overflow), K'(1));

        clear_log();
        write_both(N, 'hF00, 'hF80);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        wait_hs(5, 50, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6r_valid", K'(o_valid), K'(0));
        check("t6r_data", o_data, K'(0));
        check("t6r_idx", K'(o_idx), K'(0));
        check("t6r_last", K'(o_last), K'(0));
        check("t6r_busy", K'(busy), K'(0));
        check("t6r_ovf", K'(overflow), K'(0));
        check("t6r_state", K'(dut.state_q), K'(COLLECT));
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_iddmm_result_sel

// File: doc/iddmm_result_sel.md
# iddmm_result_sel

Consumer at the output end of the IDDMM datapath. Captures the two final-row word streams produced by the Montgomery calculation core: the raw result `A` and the conditionally reduced `A − P`. It latches the end-of-calculation sign and then replays exactly N words of the correct stream, LSW first, over a valid/ready interface to the downstream exponentiation controller. The unselected stream is discarded in lockstep.

## Interface
- `K`, 128, bits per word
- `N`, 32, words per operand
- `ADDR_W`, `$clog2(N)`, word index width
- `clk`  in  1  clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `fifo_wr_en_a`  in  1  raw-result word strobe
- `fifo_wr_data_a`  in  K  raw-result word; arrives in order, index 0 first
- `fifo_wr_en_sub`  in  1  reduced-result word strobe
- `fifo_wr_data_sub`  in  K  reduced-result word; arrives in order, index 0 first
- `cal_done`  in  1  one-cycle pulse marking end of calculation
- `cal_sign`  in  1  valid with `cal_done`; 1 selects the `sub` stream, 0 selects the `a` stream
- `o_valid`  out  1  output word valid
- `o_data`  out  K  output word
- `o_idx`  out  ADDR_W  index of `o_data`, from 0 to N−1
- `o_last`  out  1  high with index N−1
- `i_ready`  in  1  downstream accept
- `busy`  out  1  high while the block is in DRAIN
- `overflow`  out  1  sticky error; cleared only by reset

## Operation
- Two buffers, `buf_a` and `buf_sub`, each depth N and first-word-fall-through. Each buffer has its own occupancy count, `cnt_a` and `cnt_sub`, each 0 to N.
- A write strobe pushes its word when the target buffer is not full. A write strobe to a full buffer drops the word and sets `overflow`.
- Sign latch:
  - `cal_done` loads `sel` from `cal_sign` and sets `sel_vld`.
  - If `cal_done` arrives while `sel_vld` is already set and the block is in DRAIN, the sign goes to a one-deep pending register, `sel_pend`/`pend_vld`.
  - A third outstanding `cal_done` sets `overflow` and is ignored.
- State machine: COLLECT and DRAIN.
  - COLLECT → DRAIN when `cnt_a == N`, `cnt_sub == N` and `sel_vld` are all true.
  - DRAIN has `o_valid = 1`.
    - `o_data` is the head of `buf_sub` if `sel = 1`, else the head of `buf_a`.
    - `o_idx` is the drain counter.
  - On each handshake (`o_valid && i_ready`): pop both buffers and increment `o_idx`.
  - On the handshake with `o_idx == N−1`:
    - Go to COLLECT and clear `o_idx`.
    - If `pend_vld` is set, move `sel_pend` into `sel` and keep `sel_vld`; otherwise clear `sel_vld`.
- Writes during DRAIN are legal, because pops free space.
  - A push and pop in the same cycle leave that buffer's count unchanged.
  - Words from the next calculation queue behind the current N words.
- Arithmetic:
  - Counts saturate logically at N; full means `cnt == N`.
  - Pointers wrap modulo N. For non-power-of-two N, wrap explicitly at N−1.
  - No data arithmetic is performed; words pass through unmodified.

## Timing
- Reset values:
  - `o_valid`, `o_last`, `busy`, `overflow` = 0.
  - `o_data` = 0 and `o_idx` = 0.
  - Both counts and pointers = 0; `sel_vld`, `pend_vld` = 0; state = COLLECT.
- Reset mid-DRAIN: the block aborts immediately to these values. Buffered words are lost.
- Entry latency: if the DRAIN condition is true at clock edge t, `o_valid` is high after edge t+1.
- In the best case, when `cal_done` is the last event, the first word is presented 2 cycles after the `cal_done` cycle.
- Throughput is one word per cycle with `i_ready` held high: N words in N cycles.
- DRAIN always ends with COLLECT for at least one cycle, so there is no back-to-back drain.
- Stall rule: while `o_valid && !i_ready`, `o_data`, `o_idx` and `o_last` hold stable. `o_valid` never drops before the handshake.
- Simultaneous events:
  - `cal_done` in the same cycle as the final handshake while in DRAIN: it loads `sel` directly, since the current sign is released that cycle.
  - A write to a full buffer in the same cycle as a pop is accepted, not dropped.

## Structure
- Shared package `iddmm_pkg`: `K`, `N`, `ADDR_W` defaults and the state enum `sel_state_t` {COLLECT, DRAIN}.
- One sub-module, `iddmm_word_fifo`.
  - Parameterized width and depth, first-word-fall-through.
  - Ports: push, pop, data in, data out, count, full.
  - Instantiated twice: `buf_a` and `buf_sub`.
- The top level contains the sign latch, pending register, FSM, drain counter and overflow logic.

## Test plan
1. `sel = 0` path:
   - Stimulus: write `a[i] = i+1` and `sub[i] = 0x100+i` for i = 0..31; pulse `cal_done` with `cal_sign = 0`; hold `i_ready = 1`.
   - Response: 32 words, 1..32, contiguous, `o_last` on word 32; `busy` falls after the final handshake.
2. `sel = 1` path:
   - Stimulus: same writes with `cal_sign = 1`.
   - Response: 0x100..0x11F; both buffers empty afterward.
3. Backpressure:
   - Stimulus: toggle `i_ready` randomly, 50%.
   - Response: data stable during stalls; no word lost or duplicated; `o_idx` sequence 0..31.
4. Early `cal_done`:
   - Stimulus: pulse `cal_done` after 10 writes to each stream.
   - Response: DRAIN starts only 1 cycle after the 32nd write of the later stream.
5. Overlap:
   - Stimulus: during DRAIN, start the next calculation's writes and a second `cal_done` with `cal_sign = 0`.
   - Response: the first drain completes with its own sign, and the second drain follows with the pending sign; `overflow` stays 0.
6. Error and reset:
   - Stimulus: push 33 `a` words with no drain.
   - Response: `overflow = 1` and the 33rd word is dropped.
   - Stimulus: assert `rst_n` low mid-DRAIN.
   - Response: all outputs 0 and state COLLECT.
